// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the product accumulator
// and the consumer of block sums.
interface product_accumulator_if #(
    parameter int PW  = 32,
    parameter int AW  = 40,
    parameter int NUM = 8
);
    localparam int CW = $clog2(NUM + 1);

    logic          start;
    logic [PW-1:0] prod_in;
    logic          prod_valid;
    logic          prod_ready;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          acc_ack;
    logic          busy;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output start,
        output prod_in,
        output prod_valid,
        output acc_ack,
        input  prod_ready,
        input  acc_out,
        input  acc_valid,
        input  busy,
        input  count,
        input  overflow
    );

    modport slave (
        input  start,
        input  prod_in,
        input  prod_valid,
        input  acc_ack,
        output prod_ready,
        output acc_out,
        output acc_valid,
        output busy,
        output count,
        output overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums blocks of NUM unsigned products; presents each block sum
// with a valid/ack handshake and a sticky carry-out flag.
module product_accumulator #(
    parameter int PW  = 32,
    parameter int AW  = 40,
    parameter int NUM = 8
) (
    input logic clk,
    input logic rst,
    product_accumulator_if.slave bus
);
    localparam int CW = $clog2(NUM + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);

    if (AW < PW || NUM < 1) begin : g_bad_param
        $error("product_accumulator: need AW >= PW and NUM >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          valid_q;
    logic          ready_q;
    logic          busy_q;

    logic [AW:0]   sum;
    logic          beat;

    // One extra bit on the adder captures the carry out of bit AW-1.
    always_comb begin
        sum  = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, bus.prod_in};
        beat = bus.prod_valid & ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= ACCUM;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_q <= sum[AW-1:0];
                        ovf_q <= ovf_q | sum[AW];
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            state   <= HOLD;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ack) begin
                        valid_q <= 1'b0;
                        // Ack plus start chains straight into the next block.
                        if (bus.start) begin
                            state   <= ACCUM;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            ovf_q   <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.acc_out    = acc_q;
    assign bus.count      = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.acc_valid  = valid_q;
    assign bus.prod_ready = ready_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 16-bit array multiplier; consumes its 32-bit unsigned products.
- Sums a block of NUM products into a wide accumulator using a valid/ready handshake on the input side.
- Presents the finished sum with a valid/ack handshake on the output side.
- Provides a sticky overflow flag and a beat counter.

Parameters:
- PW, 32, product width; matches the 16x16 array multiplier output.
- AW, 40, accumulator width; legal range AW >= PW.
- NUM, 8, products per block; legal range NUM >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new block.
- prod_in  input  PW  unsigned product from the array multiplier.
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  block accepts a product this cycle.
- acc_out  output  AW  accumulator register value.
- acc_valid  output  1  acc_out holds a completed block sum.
- acc_ack  input  1  consumer has taken acc_out.
- busy  output  1  high in ACCUM and HOLD.
- count  output  $clog2(NUM+1)  products accepted in the current block.
- overflow  output  1  sticky; set when a carry leaves bit AW-1 in the current block.

Behaviour:
- Reset: rst high at a clock edge forces state IDLE and all outputs to 0 (acc_out, count, overflow, acc_valid, prod_ready, busy). Reset mid-block discards the partial sum with no exception.
- Outputs are registered. prod_ready is registered or decoded directly from the state register; it never combinationally depends on prod_valid.
- IDLE:
  - prod_ready=0, busy=0, acc_valid=0. acc_out, count and overflow keep the last block's values.
  - start=1 -> next cycle: state ACCUM, acc_out=0, count=0, overflow=0.
- ACCUM:
  - prod_ready=1, busy=1.
  - Beat = prod_valid & prod_ready. On a beat: acc_out <= (acc_out + zero-extended prod_in) mod 2^AW; count <= count+1; overflow <= overflow | carry-out.
  - No beat: all registers hold. Gaps in prod_valid are allowed.
  - Beat with count==NUM-1 -> next cycle: state HOLD, acc_valid=1, prod_ready=0, count=NUM, final sum on acc_out.
  - Latency: final beat accepted at edge T; acc_valid is high from edge T+1.
  - start in ACCUM is ignored.
- HOLD:
  - acc_valid=1, busy=1, prod_ready=0. acc_out, count and overflow are frozen. prod_valid is ignored.
  - acc_ack=1, start=0 -> IDLE next cycle; acc_valid drops.
  - acc_ack=1, start=1 in the same cycle -> ACCUM next cycle with acc_out, count and overflow cleared. This gives back-to-back blocks with no IDLE cycle.
  - start without acc_ack is ignored.
- NUM=1: the first beat goes straight to HOLD.
- Arithmetic: unsigned only. Wrap-around is silent apart from the overflow flag.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs -> acc_out=0, count=0, overflow=0, acc_valid=0, prod_ready=0, busy=0. Deassert rst -> block stays IDLE.
2. NUM=4: start, then products 1,2,3,4 back-to-back -> prod_ready high 4 cycles; acc_valid high exactly 1 cycle after the 4th beat; acc_out=10, count=4, overflow=0; stays in HOLD until acc_ack.
3. NUM=4: products 0x10, 0x20, 0x30, 0x40 with idle gaps of 0, 3 and 1 cycles; prod_valid=1 with 0xFFFF while in HOLD -> acc_out=0xA0; HOLD data unchanged by the held prod_valid.
4. AW=33, NUM=4: four products 0xFFFFFFFF -> acc_out=0x1_FFFF_FFFC, overflow=1. Next block with products 1,1,1,1 -> overflow=0, acc_out=4.
5. In HOLD with acc_out=10, pulse acc_ack and start in the same cycle -> next cycle ACCUM, acc_out=0, count=0, acc_valid=0. Then 5,5,5,5 -> acc_out=20.
6. Assert rst after 2 of 4 beats (partial sum 3) -> all outputs 0, IDLE. A fresh start with 2,2,2,2 -> acc_out=8.
